// File: rtl/ptw_walk_cache_pkg.sv
// Shared MMU types for the page-table walker and its page-walk cache.
package ptw_walk_cache_pkg;

  localparam int SV39_LEVELS       = 3;
  localparam int SV48_LEVELS       = 4;
  localparam int PWC_PAGE_LVL_BITS = 9;
  localparam int PWC_ASID_SIZE     = 7;
  localparam int PWC_PPN_SIZE      = 44;

  // Page-walk cache entry laid out for the default SV39 build. Parameterised
  // instances use the same field order with their own widths.
  typedef struct packed {
    logic                                     valid;
    logic                                     is_global;
    logic [PWC_ASID_SIZE-1:0]                 asid;
    logic [1:0]                               level;
    logic [SV39_LEVELS*PWC_PAGE_LVL_BITS-1:0] tag;
    logic [PWC_PPN_SIZE-1:0]                  ppn;
  } pwc_entry_t;

  // Legacy fixed SV39 PTE cache entry, kept for existing users.
  typedef struct packed {
    logic                      valid;
    logic [PWC_ASID_SIZE-1:0]  asid;
    logic [17:0]               tag;
    logic [PWC_PPN_SIZE-1:0]   ppn;
  } ptw_ptecache_entry_t;

  // Number of VPN bits, counted from the MSB, that an entry at `level` covers.
  function automatic int pwc_prefix_len(input int level, input int lvl_bits);
    return (level + 1) * lvl_bits;
  endfunction

endpackage

// File: rtl/ptw_walk_cache_match.sv
// Per-entry combinational match: prefix mask from the entry level plus the
// ASID/global qualifier.
module pwc_match
  import ptw_walk_cache_pkg::*;
#(
  parameter int LEVELS        = SV39_LEVELS,
  parameter int PAGE_LVL_BITS = 9,
  parameter int ASID_SIZE     = 7,
  localparam int VPN_W        = LEVELS * PAGE_LVL_BITS,
  localparam int LVL_W        = $clog2(LEVELS)
) (
  input  logic                 entry_valid_i,
  input  logic                 entry_global_i,
  input  logic [ASID_SIZE-1:0] entry_asid_i,
  input  logic [LVL_W-1:0]     entry_level_i,
  input  logic [VPN_W-1:0]     entry_tag_i,
  input  logic [VPN_W-1:0]     lookup_vpn_i,
  input  logic [ASID_SIZE-1:0] lookup_asid_i,
  output logic                 hit_o
);

  logic [VPN_W-1:0] prefix_mask;

  // Keep only the VPN bits above the entry's level; the rest are don't-care.
  always_comb begin
    // NOTE: default first so every path assigns the mask and no latch is inferred.
    prefix_mask = '0;
    for (int i = 0; i < VPN_W; i++) begin
      if ((VPN_W - 1 - i) < pwc_prefix_len(int'(entry_level_i), PAGE_LVL_BITS)) begin
        prefix_mask[i] = 1'b1;
      end
    end
  end

  assign hit_o = entry_valid_i
              && (entry_global_i || (entry_asid_i == lookup_asid_i))
              && (((entry_tag_i ^ lookup_vpn_i) & prefix_mask) == '0);

endmodule

// File: rtl/ptw_walk_cache.sv
// Page-walk cache: non-leaf PTE pointers tagged by VPN prefix and ASID, with
// longest-prefix lookup, de-duplicated fills, round-robin eviction and flushes.
module ptw_walk_cache
  import ptw_walk_cache_pkg::*;
#(
  parameter int ENTRIES       = 8,
  parameter int LEVELS        = SV39_LEVELS,
  parameter int PAGE_LVL_BITS = 9,
  parameter int ASID_SIZE     = 7,
  parameter int PPN_SIZE      = 44,
  localparam int VPN_W        = LEVELS * PAGE_LVL_BITS,
  localparam int LVL_W        = $clog2(LEVELS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lookup_valid_i,
  input  logic [VPN_W-1:0]     lookup_vpn_i,
  input  logic [ASID_SIZE-1:0] lookup_asid_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [LVL_W-1:0]     resp_level_o,
  output logic [PPN_SIZE-1:0]  resp_ppn_o,
  input  logic                 fill_valid_i,
  input  logic [VPN_W-1:0]     fill_vpn_i,
  input  logic [ASID_SIZE-1:0] fill_asid_i,
  input  logic [LVL_W-1:0]     fill_level_i,
  input  logic [PPN_SIZE-1:0]  fill_ppn_i,
  input  logic                 fill_global_i,
  input  logic                 flush_i,
  input  logic                 flush_asid_valid_i,
  input  logic [ASID_SIZE-1:0] flush_asid_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic                 valid;
    logic                 is_global;
    logic [ASID_SIZE-1:0] asid;
    logic [LVL_W-1:0]     level;
    logic [VPN_W-1:0]     tag;
    logic [PPN_SIZE-1:0]  ppn;
  } entry_t;

  entry_t               entries_q [ENTRIES];
  logic [IDX_W-1:0]     rr_q;
  logic [ENTRIES-1:0]   hit;

  logic                 best_found;
  logic [LVL_W-1:0]     best_level;
  logic [PPN_SIZE-1:0]  best_ppn;

  logic                 fill_ok;
  logic [VPN_W-1:0]     fill_mask;
  logic                 dedup_found;
  logic [IDX_W-1:0]     dedup_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     alloc_idx;

  logic                 resp_valid_q;
  logic                 resp_hit_q;
  logic [LVL_W-1:0]     resp_level_q;
  logic [PPN_SIZE-1:0]  resp_ppn_q;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    pwc_match #(
      .LEVELS        (LEVELS),
      .PAGE_LVL_BITS (PAGE_LVL_BITS),
      .ASID_SIZE     (ASID_SIZE)
    ) u_match (
      .entry_valid_i  (entries_q[g].valid),
      .entry_global_i (entries_q[g].is_global),
      .entry_asid_i   (entries_q[g].asid),
      .entry_level_i  (entries_q[g].level),
      .entry_tag_i    (entries_q[g].tag),
      .lookup_vpn_i   (lookup_vpn_i),
      .lookup_asid_i  (lookup_asid_i),
      .hit_o          (hit[g])
    );
  end

  // Deepest matching level wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_level = '0;
    best_ppn   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit[i] && (!best_found || (entries_q[i].level > best_level))) begin
        best_found = 1'b1;
        best_level = entries_q[i].level;
        best_ppn   = entries_q[i].ppn;
      end
    end
  end

  // Fill target: an existing twin entry, else the lowest free slot, else rr.
  always_comb begin
    fill_ok     = fill_valid_i && (int'(fill_level_i) <= LEVELS - 2);
    fill_mask   = '0;
    dedup_found = 1'b0;
    dedup_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int b = 0; b < VPN_W; b++) begin
      if ((VPN_W - 1 - b) < pwc_prefix_len(int'(fill_level_i), PAGE_LVL_BITS)) begin
        fill_mask[b] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (!dedup_found && entries_q[i].valid
          && (entries_q[i].level == fill_level_i)
          && (((entries_q[i].tag ^ fill_vpn_i) & fill_mask) == '0)
          && ((entries_q[i].asid == fill_asid_i)
              || (entries_q[i].is_global && fill_global_i))) begin
        dedup_found = 1'b1;
        dedup_idx   = IDX_W'(i);
      end
      if (!free_found && !entries_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    alloc_idx = free_found ? free_idx : rr_q;
  end

  // Array update: reset, then full flush, then ASID flush, then fill.
  always_ff @(posedge clk_i) begin
    // NOTE: only the valid bits and rr are reset; payload is gated by valid.
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
      rr_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
    end else if (flush_asid_valid_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!entries_q[i].is_global && (entries_q[i].asid == flush_asid_i)) begin
          entries_q[i].valid <= 1'b0;
        end
      end
    end else if (fill_ok) begin
      if (dedup_found) begin
        entries_q[dedup_idx].ppn       <= fill_ppn_i;
        entries_q[dedup_idx].is_global <= fill_global_i;
      end else begin
        entries_q[alloc_idx] <= '{valid:     1'b1,
                                  is_global: fill_global_i,
                                  asid:      fill_asid_i,
                                  level:     fill_level_i,
                                  tag:       fill_vpn_i,
                                  ppn:       fill_ppn_i};
        if (!free_found) begin
          rr_q <= (int'(rr_q) == ENTRIES - 1) ? '0 : rr_q + IDX_W'(1);
        end
      end
    end
  end

  // Registered response: one-cycle pulse, payload zeroed on miss or idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_level_q <= '0;
      resp_ppn_q   <= '0;
    end else begin
      resp_valid_q <= lookup_valid_i;
      resp_hit_q   <= lookup_valid_i && best_found;
      resp_level_q <= (lookup_valid_i && best_found) ? best_level : '0;
      resp_ppn_q   <= (lookup_valid_i && best_found) ? best_ppn : '0;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_level_o = resp_level_q;
  assign resp_ppn_o   = resp_ppn_q;

endmodule

// File: tb/tb_ptw_walk_cache.sv
// Directed bench for ptw_walk_cache: an SV39 instance (ENTRIES=8) and an SV48
// instance, with expected responses queued at issue and compared on arrival.
module tb_ptw_walk_cache;

  typedef struct {
    logic        hit;
    logic [1:0]  level;
    logic [43:0] ppn;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  logic pend3 = 1'b0;
  logic pend4 = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   nid = 0;
  exp_t q3[$];
  exp_t q4[$];

  // SV39 instance signals
  logic        lv3 = 0, fv3 = 0, fg3 = 0, fl3 = 0, fav3 = 0;
  logic [26:0] lvpn3 = 0, fvpn3 = 0;
  logic [6:0]  lasid3 = 0, fasid3 = 0, fa3 = 0;
  logic [1:0]  flvl3 = 0;
  logic [43:0] fppn3 = 0;
  logic        rv3, rh3;
  logic [1:0]  rl3;
  logic [43:0] rp3;

  // SV48 instance signals
  logic        lv4 = 0, fv4 = 0, fg4 = 0, fl4 = 0, fav4 = 0;
  logic [35:0] lvpn4 = 0, fvpn4 = 0;
  logic [6:0]  lasid4 = 0, fasid4 = 0, fa4 = 0;
  logic [1:0]  flvl4 = 0;
  logic [43:0] fppn4 = 0;
  logic        rv4, rh4;
  logic [1:0]  rl4;
  logic [43:0] rp4;

  always #5 clk = ~clk;

  ptw_walk_cache #(.ENTRIES(8), .LEVELS(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lv3), .lookup_vpn_i(lvpn3), .lookup_asid_i(lasid3),
    .resp_valid_o(rv3), .resp_hit_o(rh3), .resp_level_o(rl3), .resp_ppn_o(rp3),
    .fill_valid_i(fv3), .fill_vpn_i(fvpn3), .fill_asid_i(fasid3),
    .fill_level_i(flvl3), .fill_ppn_i(fppn3), .fill_global_i(fg3),
    .flush_i(fl3), .flush_asid_valid_i(fav3), .flush_asid_i(fa3)
  );

  ptw_walk_cache #(.ENTRIES(8), .LEVELS(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lv4), .lookup_vpn_i(lvpn4), .lookup_asid_i(lasid4),
    .resp_valid_o(rv4), .resp_hit_o(rh4), .resp_level_o(rl4), .resp_ppn_o(rp4),
    .fill_valid_i(fv4), .fill_vpn_i(fvpn4), .fill_asid_i(fasid4),
    .fill_level_i(flvl4), .fill_ppn_i(fppn4), .fill_global_i(fg4),
    .flush_i(fl4), .flush_asid_valid_i(fav4), .flush_asid_i(fa4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A lookup accepted at an edge (not under reset) owes a response next cycle.
  always @(posedge clk) begin
    pend3 = lv3 && !rst;
    pend4 = lv4 && !rst;
  end

  // Compare responses half a cycle after the edge that produced them.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (pend3) begin
        check("dut3 queue nonempty", 64'(q3.size() != 0), 64'd1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          check($sformatf("dut3 rsp%0d valid", e.id), 64'(rv3), 64'd1);
          check($sformatf("dut3 rsp%0d hit", e.id),   64'(rh3), 64'(e.hit));
          check($sformatf("dut3 rsp%0d level", e.id), 64'(rl3), 64'(e.level));
          check($sformatf("dut3 rsp%0d ppn", e.id),   64'(rp3), 64'(e.ppn));
        end
      end else begin
        check("dut3 idle outputs", 64'({rv3, rh3, rl3, rp3}), 64'd0);
      end
      if (pend4) begin
        check("dut4 queue nonempty", 64'(q4.size() != 0), 64'd1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          check($sformatf("dut4 rsp%0d valid", e.id), 64'(rv4), 64'd1);
          check($sformatf("dut4 rsp%0d hit", e.id),   64'(rh4), 64'(e.hit));
          check($sformatf("dut4 rsp%0d level", e.id), 64'(rl4), 64'(e.level));
          check($sformatf("dut4 rsp%0d ppn", e.id),   64'(rp4), 64'(e.ppn));
        end
      end else begin
        check("dut4 idle outputs", 64'({rv4, rh4, rl4, rp4}), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lv3 = 0; fv3 = 0; fl3 = 0; fav3 = 0;
    lv4 = 0; fv4 = 0;
  endtask

  task automatic set_lookup(input bit d4, input logic [35:0] vpn, input logic [6:0] asid,
                            input logic hit, input logic [1:0] lvl, input logic [43:0] ppn);
    exp_t e;
    e.hit   = hit;
    e.level = hit ? lvl : 2'd0;
    e.ppn   = hit ? ppn : 44'd0;
    e.id    = nid++;
    if (d4) begin
      q4.push_back(e);
      lv4 = 1; lvpn4 = vpn; lasid4 = asid;
    end else begin
      q3.push_back(e);
      lv3 = 1; lvpn3 = vpn[26:0]; lasid3 = asid;
    end
  endtask

  task automatic set_fill(input bit d4, input logic [35:0] vpn, input logic [6:0] asid,
                          input logic [1:0] lvl, input logic [43:0] ppn, input logic glob);
    if (d4) begin
      fv4 = 1; fvpn4 = vpn; fasid4 = asid; flvl4 = lvl; fppn4 = ppn; fg4 = glob;
    end else begin
      fv3 = 1; fvpn3 = vpn[26:0]; fasid3 = asid; flvl3 = lvl; fppn3 = ppn; fg3 = glob;
    end
  endtask

  task automatic lookup(input bit d4, input logic [35:0] vpn, input logic [6:0] asid,
                        input logic hit, input logic [1:0] lvl, input logic [43:0] ppn);
    set_lookup(d4, vpn, asid, hit, lvl, ppn);
    tick();
  endtask

  task automatic fill(input bit d4, input logic [35:0] vpn, input logic [6:0] asid,
                      input logic [1:0] lvl, input logic [43:0] ppn, input logic glob);
    set_fill(d4, vpn, asid, lvl, ppn, glob);
    tick();
  endtask

  // Level-0 prefix k of the SV39 VPN.
  function automatic logic [35:0] kvpn(input int k);
    return 36'(k) << 18;
  endfunction

  initial begin
    // Reset, checking idle outputs while it is held.
    @(posedge clk);
    mon_en = 1;
    @(posedge clk);
    #1 rst = 0;

    // Cold lookup misses.
    lookup(0, 36'h1234567, 7'd1, 0, 2'd0, 44'h0);

    // Longest-prefix selection.
    fill(0, 36'h4000000, 7'd1, 2'd0, 44'hA, 0);
    fill(0, 36'h4000000, 7'd1, 2'd1, 44'hB, 0);
    lookup(0, 36'h40001FF, 7'd1, 1, 2'd1, 44'hB);
    lookup(0, 36'h4020000, 7'd1, 1, 2'd0, 44'hA);
    lookup(0, 36'h40001FF, 7'd2, 0, 2'd0, 44'h0);

    // Global entries and ASID-selective flush.
    fill(0, 36'h2000000, 7'd3, 2'd0, 44'hC, 1);
    lookup(0, 36'h2000000, 7'd5, 1, 2'd0, 44'hC);
    fav3 = 1; fa3 = 7'd3; tick();
    lookup(0, 36'h2000000, 7'd5, 1, 2'd0, 44'hC);
    fav3 = 1; fa3 = 7'd1; tick();
    lookup(0, 36'h40001FF, 7'd1, 0, 2'd0, 44'h0);
    // A same-cycle flush does not suppress the hit; the next lookup misses.
    set_lookup(0, 36'h2000000, 7'd5, 1, 2'd0, 44'hC);
    fl3 = 1;
    tick();
    lookup(0, 36'h2000000, 7'd5, 0, 2'd0, 44'h0);

    // Round-robin replacement and in-place refill.
    for (int k = 1; k <= 8; k++) fill(0, kvpn(k), 7'd1, 2'd0, 44'(16 + k), 0);
    lookup(0, kvpn(5), 7'd1, 1, 2'd0, 44'h15);
    fill(0, kvpn(9), 7'd1, 2'd0, 44'h19, 0);
    lookup(0, kvpn(1), 7'd1, 0, 2'd0, 44'h0);
    lookup(0, kvpn(9), 7'd1, 1, 2'd0, 44'h19);
    fill(0, kvpn(10), 7'd1, 2'd0, 44'h1A, 0);
    lookup(0, kvpn(2), 7'd1, 0, 2'd0, 44'h0);
    lookup(0, kvpn(10), 7'd1, 1, 2'd0, 44'h1A);
    fill(0, kvpn(3), 7'd1, 2'd0, 44'h33, 0);
    lookup(0, kvpn(3), 7'd1, 1, 2'd0, 44'h33);
    fill(0, kvpn(11), 7'd1, 2'd0, 44'h1B, 0);
    lookup(0, kvpn(3), 7'd1, 0, 2'd0, 44'h0);
    lookup(0, kvpn(4), 7'd1, 1, 2'd0, 44'h14);
    lookup(0, kvpn(11), 7'd1, 1, 2'd0, 44'h1B);
    // Level LEVELS-1 fill is ignored and evicts nothing.
    fill(0, kvpn(12), 7'd1, 2'd2, 44'h1C, 0);
    lookup(0, kvpn(12), 7'd1, 0, 2'd0, 44'h0);
    lookup(0, kvpn(4), 7'd1, 1, 2'd0, 44'h14);

    // Same-cycle fill/lookup and fill/flush interactions.
    fl3 = 1; tick();
    set_fill(0, 36'h5000000, 7'd1, 2'd0, 44'h55, 0);
    set_lookup(0, 36'h5000000, 7'd1, 0, 2'd0, 44'h0);
    tick();
    lookup(0, 36'h5000000, 7'd1, 1, 2'd0, 44'h55);
    set_fill(0, 36'h5800000, 7'd1, 2'd0, 44'h58, 0);
    fl3 = 1;
    tick();
    lookup(0, 36'h5800000, 7'd1, 0, 2'd0, 44'h0);
    lookup(0, 36'h5000000, 7'd1, 0, 2'd0, 44'h0);
    set_fill(0, 36'h5800000, 7'd1, 2'd0, 44'h58, 0);
    fav3 = 1; fa3 = 7'd7;
    tick();
    lookup(0, 36'h5800000, 7'd1, 0, 2'd0, 44'h0);

    // Same-level tie: lowest index wins; global refill dedups in place.
    fill(0, 36'h3000000, 7'd3, 2'd0, 44'h61, 1);
    fill(0, 36'h3000000, 7'd1, 2'd0, 44'h62, 0);
    lookup(0, 36'h3000000, 7'd1, 1, 2'd0, 44'h61);
    fill(0, 36'h3000000, 7'd5, 2'd0, 44'h63, 1);
    lookup(0, 36'h3000000, 7'd1, 1, 2'd0, 44'h63);
    lookup(0, 36'h3000000, 7'd9, 1, 2'd0, 44'h63);

    // Reset mid-operation discards the pending response and clears the array.
    lookup(0, 36'h3000000, 7'd1, 1, 2'd0, 44'h63);
    lv3 = 1; lvpn3 = 27'h3000000; lasid3 = 7'd1; rst = 1;
    tick();
    rst = 0;
    lookup(0, 36'h3000000, 7'd1, 0, 2'd0, 44'h0);

    // SV48 instance: level-2 prefix of 27 bits, and an ignored level-3 fill.
    fill(1, 36'h123456789, 7'd2, 2'd2, 44'h77, 0);
    lookup(1, 36'h1234566AB, 7'd2, 1, 2'd2, 44'h77);
    lookup(1, 36'h123456589, 7'd2, 0, 2'd0, 44'h0);
    fill(1, 36'h0AA000000, 7'd2, 2'd3, 44'h88, 0);
    lookup(1, 36'h0AA000000, 7'd2, 0, 2'd0, 44'h0);

    tick();
    tick();
    check("dut3 responses outstanding", 64'(q3.size()), 64'd0);
    check("dut4 responses outstanding", 64'(q4.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
